pe_config_loader: RTL and testbench

Initiator side of the PE status-register configuration port. During IO mode at boot it accepts a stream of 16-bit host words (header followed by payload) over a valid/ready handshake and converts each payload word into one `write_en/write_addr/write_data` transaction to the PE status-register file. Addresses follow the fixed even-address map. The target is one PE by index, or all PEs by broadcast. It sits between the IO front end and the PE array; each PE qualifies the write against its own `PE_IDX`.

---
 rtl/pe_config_loader_pkg.sv | 27 ++
 rtl/pe_config_loader.sv | 152 +++++++++++++++
 tb/tb_pe_config_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pe_config_loader_pkg.sv
// pe_config_loader_pkg
//   Shared definitions for the PE status-register configuration port.
//   Holds the status bus widths, the register-slot count, the header
//   field positions of a configuration packet and the loader FSM encoding.
package pe_config_loader_pkg;

    // Status-register bus geometry.
    localparam int PE_STATUS_ADDR_WIDTH = 6;
    localparam int PE_STATUS_DATA_WIDTH = 16;
    localparam int NUM_STATUS_REGS      = 19;
    localparam int PE_IDX_WIDTH         = 6;
    localparam int SLOT_WIDTH           = 5;

    typedef logic [PE_STATUS_DATA_WIDTH-1:0] PeStatusDataBus;

    // Header word layout: [15] bcast, [14:9] pe_idx, [8:5] reserved, [4:0] count.
    localparam int CFG_HDR_BCAST     = 15;
    localparam int CFG_HDR_PE_IDX    = 9;   // lsb of the pe_idx field
    localparam int CFG_HDR_COUNT     = 0;   // lsb of the count field

    // Loader FSM encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } cfg_state_t;

endpackage : pe_config_loader_pkg

// File: rtl/pe_config_loader.sv
// pe_config_loader
//   Initiator side of the PE status-register configuration port. Accepts a
//   header word followed by `count` payload words from the host over a
//   valid/ready handshake and turns each payload word into one registered
//   write to status slot j (address 2j) of one PE, or of all PEs on broadcast.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   in_valid      in   host word valid
//   in_ready      out  loader can accept a word (always, the sink never stalls)
//   in_data       in   host word (header or payload)
//   write_en      out  one-cycle status write strobe per payload word
//   write_addr    out  status address, always even
//   write_data    out  status write data
//   write_pe_idx  out  target PE index from the latest legal header
//   write_bcast   out  broadcast flag from the latest legal header
//   busy          out  a packet is in progress
//   done          out  pulses together with the last write of a packet
//   err           out  sticky bad-header flag, cleared only by rst
module pe_config_loader
    import pe_config_loader_pkg::*;
#(
    parameter int DATA_W   = PE_STATUS_DATA_WIDTH,
    parameter int ADDR_W   = PE_STATUS_ADDR_WIDTH,
    parameter int NUM_REGS = NUM_STATUS_REGS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    write_en,
    output logic [ADDR_W-1:0]       write_addr,
    output logic [DATA_W-1:0]       write_data,
    output logic [PE_IDX_WIDTH-1:0] write_pe_idx,
    output logic                    write_bcast,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [SLOT_WIDTH-1:0] MAX_COUNT = SLOT_WIDTH'(NUM_REGS);

    cfg_state_t              state_q,  state_d;
    logic [SLOT_WIDTH-1:0]   slot_q,   slot_d;
    logic [SLOT_WIDTH-1:0]   count_q,  count_d;
    logic                    bcast_q,  bcast_d;
    logic [PE_IDX_WIDTH-1:0] pe_idx_q, pe_idx_d;
    logic                    wen_q,    wen_d;
    logic [ADDR_W-1:0]       addr_q,   addr_d;
    logic [DATA_W-1:0]       data_q,   data_d;
    logic                    done_q,   done_d;
    logic                    err_q,    err_d;

    // Header field views of the incoming word.
    logic                    hdr_bcast;
    logic [PE_IDX_WIDTH-1:0] hdr_pe_idx;
    logic [SLOT_WIDTH-1:0]   hdr_count;
    logic                    hdr_legal;

    assign hdr_bcast  = in_data[CFG_HDR_BCAST];
    assign hdr_pe_idx = in_data[CFG_HDR_PE_IDX +: PE_IDX_WIDTH];
    assign hdr_count  = in_data[CFG_HDR_COUNT +: SLOT_WIDTH];
    assign hdr_legal  = (hdr_count != '0) && (hdr_count <= MAX_COUNT);

    // The status-register sink never back-pressures, so both states accept.
    assign in_ready = 1'b1;

    // NOTE: every signal is given its hold/default value before the case
    // statement so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        count_d  = count_q;
        bcast_d  = bcast_q;
        pe_idx_d = pe_idx_q;
        wen_d    = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (hdr_legal) begin
                        bcast_d  = hdr_bcast;
                        pe_idx_d = hdr_pe_idx;
                        count_d  = hdr_count;
                        slot_d   = '0;
                        state_d  = ST_DATA;
                    end else begin
                        // Bad header is swallowed; the next word is a new header.
                        err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    wen_d  = 1'b1;
                    addr_d = ADDR_W'({slot_q, 1'b0});
                    data_d = in_data;
                    slot_d = slot_q + 1'b1;
                    if (slot_q == count_q - 1'b1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            count_q  <= '0;
            bcast_q  <= 1'b0;
            pe_idx_q <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            count_q  <= count_d;
            bcast_q  <= bcast_d;
            pe_idx_q <= pe_idx_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign write_en     = wen_q;
    assign write_addr   = addr_q;
    assign write_data   = data_q;
    assign write_pe_idx = pe_idx_q;
    assign write_bcast  = bcast_q;
    assign busy         = (state_q == ST_DATA);
    assign done         = done_q;
    assign err          = err_q;

endmodule : pe_config_loader

// File: tb/tb_pe_config_loader.sv
// tb_pe_config_loader
//   Directed bench for pe_config_loader: full 19-word packet, broadcast,
//   illegal headers, input gaps and reset mid-packet. Inputs change 1 ns
//   after the rising edge; outputs are checked there too, so every check sees
//   the registered result of the handshake at the edge just passed.
module tb_pe_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        write_en;
    logic [5:0]  write_addr;
    logic [15:0] write_data;
    logic [5:0]  write_pe_idx;
    logic        write_bcast;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_config_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_pe_idx (write_pe_idx),
        .write_bcast  (write_bcast),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word (or a gap) for a single clock edge.
    task automatic cycle(input logic valid, input logic [15:0] data);
        in_valid = valid;
        in_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [5:0] addr,
                               input logic [15:0] data, input logic last);
        check({tag, ".we"},   32'(write_en),   32'd1);
        check({tag, ".addr"}, 32'(write_addr), 32'(addr));
        check({tag, ".data"}, 32'(write_data), 32'(data));
        check({tag, ".done"}, 32'(done),       32'(last));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".we"},    32'(write_en),     32'd0);
        check({tag, ".addr"},  32'(write_addr),   32'd0);
        check({tag, ".data"},  32'(write_data),   32'd0);
        check({tag, ".pe"},    32'(write_pe_idx), 32'd0);
        check({tag, ".bcast"}, 32'(write_bcast),  32'd0);
        check({tag, ".busy"},  32'(busy),         32'd0);
        check({tag, ".done"},  32'(done),         32'd0);
        check({tag, ".err"},   32'(err),          32'd0);
        check({tag, ".ready"}, 32'(in_ready),     32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1) pe_idx 5, count 19, words back to back.
        cycle(1'b1, 16'h0A13);
        check("hdr19.we",    32'(write_en),     32'd0);
        check("hdr19.busy",  32'(busy),         32'd1);
        check("hdr19.pe",    32'(write_pe_idx), 32'd5);
        check("hdr19.bcast", 32'(write_bcast),  32'd0);
        for (int j = 0; j < 19; j++) begin
            cycle(1'b1, 16'h0100 + 16'(j));
            check_write($sformatf("p19[%0d]", j), 6'(2 * j), 16'h0100 + 16'(j), j == 18);
            check($sformatf("p19[%0d].pe", j),   32'(write_pe_idx), 32'd5);
            check($sformatf("p19[%0d].busy", j), 32'(busy),         (j == 18) ? 32'd0 : 32'd1);
        end
        cycle(1'b0, 16'hFFFF);
        check("p19.after.we",   32'(write_en), 32'd0);
        check("p19.after.done", 32'(done),     32'd0);

        // 2) broadcast, one word.
        cycle(1'b1, 16'h8001);
        check("bc.hdr.bcast", 32'(write_bcast),  32'd1);
        check("bc.hdr.pe",    32'(write_pe_idx), 32'd0);
        check("bc.hdr.busy",  32'(busy),         32'd1);
        cycle(1'b1, 16'h0003);
        check_write("bc.w0", 6'd0, 16'h0003, 1'b1);
        check("bc.w0.bcast", 32'(write_bcast), 32'd1);
        check("bc.w0.busy",  32'(busy),        32'd0);
        cycle(1'b0, 16'h0000);
        check("bc.after.busy", 32'(busy),     32'd0);
        check("bc.after.we",   32'(write_en), 32'd0);

        // 3) illegal counts 0 and 20, then a legal two-word packet.
        cycle(1'b1, 16'h0200);
        check("cnt0.we",   32'(write_en), 32'd0);
        check("cnt0.err",  32'(err),      32'd1);
        check("cnt0.busy", 32'(busy),     32'd0);
        cycle(1'b1, 16'h0214);
        check("cnt20.we",    32'(write_en),     32'd0);
        check("cnt20.err",   32'(err),          32'd1);
        check("cnt20.busy",  32'(busy),         32'd0);
        check("cnt20.pe",    32'(write_pe_idx), 32'd0);
        check("cnt20.bcast", 32'(write_bcast),  32'd1);
        cycle(1'b1, 16'h0202);
        check("cnt2.hdr.pe",    32'(write_pe_idx), 32'd1);
        check("cnt2.hdr.bcast", 32'(write_bcast),  32'd0);
        cycle(1'b1, 16'hAAAA);
        check_write("cnt2.w0", 6'd0, 16'hAAAA, 1'b0);
        cycle(1'b1, 16'h5555);
        check_write("cnt2.w1", 6'd2, 16'h5555, 1'b1);
        check("cnt2.err", 32'(err), 32'd1);

        // 4) count 4 with a three-cycle gap between words 1 and 2.
        cycle(1'b1, 16'h0404);
        check("gap.hdr.pe", 32'(write_pe_idx), 32'd2);
        cycle(1'b1, 16'h0011);
        check_write("gap.w0", 6'd0, 16'h0011, 1'b0);
        cycle(1'b1, 16'h0022);
        check_write("gap.w1", 6'd2, 16'h0022, 1'b0);
        for (int g = 0; g < 3; g++) begin
            cycle(1'b0, 16'hDEAD);
            check($sformatf("gap.idle[%0d].we", g),   32'(write_en), 32'd0);
            check($sformatf("gap.idle[%0d].busy", g), 32'(busy),     32'd1);
            check($sformatf("gap.idle[%0d].done", g), 32'(done),     32'd0);
        end
        cycle(1'b1, 16'h0033);
        check_write("gap.w2", 6'd4, 16'h0033, 1'b0);
        check("gap.w2.busy", 32'(busy), 32'd1);
        cycle(1'b1, 16'h0044);
        check_write("gap.w3", 6'd6, 16'h0044, 1'b1);
        check("gap.w3.busy", 32'(busy), 32'd0);

        // 5) reset after 2 of 5 words; next word after release is a header.
        cycle(1'b1, 16'h0605);
        check("rst.hdr.pe", 32'(write_pe_idx), 32'd3);
        cycle(1'b1, 16'h1111);
        check_write("rst.w0", 6'd0, 16'h1111, 1'b0);
        cycle(1'b1, 16'h2222);
        check_write("rst.w1", 6'd2, 16'h2222, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        check_reset_values("midrst.hold");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 16'h0001);
        check("post.hdr.we",   32'(write_en), 32'd0);
        check("post.hdr.busy", 32'(busy),     32'd1);
        cycle(1'b1, 16'h7777);
        check_write("post.w0", 6'd0, 16'h7777, 1'b1);
        check("post.w0.busy", 32'(busy), 32'd0);
        cycle(1'b0, 16'h0000);
        check("post.after.we", 32'(write_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pe_config_loader
